// File: rtl/tile_pixel_gen.sv
// Streams every pixel of one 40x40 tile in raster order: absolute and tile-relative
// coordinates plus the linear frame-buffer address, with valid/ready backpressure.
module tile_pixel_gen #(
    parameter int TILE_W   = 40,
    parameter int TILE_H   = 40,
    parameter int TILES_X  = 16,
    parameter int TILES_Y  = 12,
    parameter int SCREEN_W = 640
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  tile_x,
    input  logic [3:0]  tile_y,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  draw_x,
    output logic [9:0]  draw_y,
    output logic [5:0]  rel_x,
    output logic [5:0]  rel_y,
    output logic [18:0] fb_addr,
    output logic        pix_last,
    output logic        done,
    output logic        err
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; a
    // producer holding valid keeps its payload stable until that edge.
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} state_t;

    state_t      state, state_next;
    logic [3:0]  tx_q, ty_q;
    logic [9:0]  base_x, base_y;
    logic [18:0] row_addr;
    logic [9:0]  load_x, load_y;
    logic [18:0] load_row;
    logic [5:0]  rel_x_next, rel_y_next;
    logic [18:0] row_next;
    logic [9:0]  draw_x_next, draw_y_next;
    logic        accept, beat, end_row, end_tile, bad_tile;

    assign accept   = (state == IDLE) && req_valid;
    assign beat     = (state == RUN) && pix_ready;
    assign end_row  = (rel_x == 6'(TILE_W - 1));
    assign end_tile = end_row && (rel_y == 6'(TILE_H - 1));
    assign bad_tile = ({1'b0, tile_x} >= 5'(TILES_X)) || ({1'b0, tile_y} >= 5'(TILES_Y));

    // Shift-add forms of x*40 and y*640 keep multipliers out of the netlist.
    assign load_x   = {1'b0, tx_q, 5'b0} + {3'b0, tx_q, 3'b0};
    assign load_y   = {1'b0, ty_q, 5'b0} + {3'b0, ty_q, 3'b0};
    assign load_row = {load_y, 9'b0} + {2'b0, load_y, 7'b0};

    assign rel_x_next  = end_row ? 6'd0 : rel_x + 6'd1;
    assign rel_y_next  = end_row ? rel_y + 6'd1 : rel_y;
    assign row_next    = end_row ? row_addr + 19'(SCREEN_W) : row_addr;
    assign draw_x_next = base_x + {4'b0, rel_x_next};
    assign draw_y_next = base_y + {4'b0, rel_y_next};

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = bad_tile ? ERR : LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (beat && end_tile) state_next = DONE;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            tx_q     <= '0;
            ty_q     <= '0;
            base_x   <= '0;
            base_y   <= '0;
            row_addr <= '0;
            rel_x    <= '0;
            rel_y    <= '0;
            draw_x   <= '0;
            draw_y   <= '0;
            fb_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_q <= tile_x;
                        ty_q <= tile_y;
                    end
                end
                LOAD: begin
                    base_x   <= load_x;
                    base_y   <= load_y;
                    row_addr <= load_row;
                    rel_x    <= '0;
                    rel_y    <= '0;
                    draw_x   <= load_x;
                    draw_y   <= load_y;
                    fb_addr  <= load_row + {9'b0, load_x};
                end
                RUN: begin
                    // The final beat leaves the outputs holding the last pixel.
                    if (beat && !end_tile) begin
                        rel_x    <= rel_x_next;
                        rel_y    <= rel_y_next;
                        row_addr <= row_next;
                        draw_x   <= draw_x_next;
                        draw_y   <= draw_y_next;
                        fb_addr  <= row_next + {9'b0, draw_x_next};
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign pix_valid = (state == RUN);
    assign pix_last  = (state == RUN) && end_tile;
    assign done      = (state == DONE);
    assign err       = (state == ERR);

endmodule

// File: tb/tb_tile_pixel_gen.sv
// Self-checking bench for tile_pixel_gen: random tiles and backpressure checked
// against a per-tile pixel list computed directly from tile geometry.
module tb_tile_pixel_gen;

    localparam int TW = 40;
    localparam int TH = 40;
    localparam int SW = 640;
    localparam logic [63:0] IDLE_VIEW = {8'b0, 1'b1, 55'b0};

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  tile_x = '0;
    logic [3:0]  tile_y = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [9:0]  draw_x, draw_y;
    logic [5:0]  rel_x, rel_y;
    logic [18:0] fb_addr;
    logic        pix_last, done, err;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    tile_pixel_gen dut (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
        .tile_x(tile_x), .tile_y(tile_y), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .draw_x(draw_x), .draw_y(draw_y), .rel_x(rel_x), .rel_y(rel_y),
        .fb_addr(fb_addr), .pix_last(pix_last), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Layout: {pad, req_ready, done, err, pix_valid, pix_last, draw_x, draw_y, rel_x, rel_y, fb_addr}
    function automatic logic [63:0] view();
        return {8'b0, req_ready, done, err, pix_valid, pix_last,
                draw_x, draw_y, rel_x, rel_y, fb_addr};
    endfunction

    function automatic logic [63:0] exp_beat(int tx, int ty, int rx, int ry);
        int   dx = tx * TW + rx;
        int   dy = ty * TH + ry;
        logic last = (rx == TW - 1) && (ry == TH - 1);
        return {8'b0, 1'b0, 1'b0, 1'b0, 1'b1, last,
                10'(dx), 10'(dy), 6'(rx), 6'(ry), 19'(dy * SW + dx)};
    endfunction

    task automatic issue(input int tx, input int ty);
        int w = 0;
        while (!req_ready && w < 100) begin
            @(posedge Clk); #1;
            w++;
        end
        check_eq("req_ready_wait", {63'b0, req_ready}, 64'd1);
        tile_x    = 4'(tx);
        tile_y    = 4'(ty);
        req_valid = 1'b1;
        @(posedge Clk); #1;
        req_valid = 1'b0;
    endtask

    // Entered one cycle after acceptance (LOAD). Returns in the first IDLE cycle,
    // or right after the reset edge when abort_at is reached.
    task automatic stream_tile(input int tx, input int ty, input bit gated,
                               input int abort_at, output int beats);
        int  budget = 20000;
        bit  aborted = 1'b0;
        beats = 0;
        for (int ry = 0; ry < TH; ry++)
            for (int rx = 0; rx < TW; rx++)
                exp_q.push_back(exp_beat(tx, ty, rx, ry));
        check_eq("load_quiet", {62'b0, pix_valid, req_ready}, 64'd0);
        @(posedge Clk); #1;
        check_eq("first_valid", {63'b0, pix_valid}, 64'd1);
        while (exp_q.size() > 0 && budget > 0 && !aborted) begin
            pix_ready = gated ? 1'($urandom_range(0, 1)) : 1'b1;
            check_eq("beat", view(), exp_q[0]);
            if (pix_ready) begin
                void'(exp_q.pop_front());
                beats++;
            end
            if (beats == abort_at) begin
                Reset = 1'b1;
                @(posedge Clk); #1;
                Reset = 1'b0;
                check_eq("abort_reset_view", view(), IDLE_VIEW);
                @(posedge Clk); #1;
                check_eq("abort_no_done", {62'b0, done, req_ready}, 64'd1);
                exp_q.delete();
                aborted = 1'b1;
            end else begin
                @(posedge Clk); #1;
                budget--;
            end
        end
        if (budget == 0) begin
            check_eq("stream_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        if (!aborted) begin
            check_eq("done_cycle", {59'b0, req_ready, done, err, pix_valid, pix_last}, 64'b01000);
            @(posedge Clk); #1;
            check_eq("idle_after_done", {61'b0, req_ready, done, pix_valid}, 64'b100);
        end
    endtask

    initial begin
        int b;
        int tx, ty;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("reset_view", view(), IDLE_VIEW);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check_eq("idle_view", view(), IDLE_VIEW);

        issue(0, 0);
        stream_tile(0, 0, 1'b0, -1, b);
        check_eq("beats_0_0", 64'(b), 64'd1600);

        issue(15, 11);
        stream_tile(15, 11, 1'b0, -1, b);
        check_eq("beats_15_11", 64'(b), 64'd1600);

        issue(3, 2);
        stream_tile(3, 2, 1'b1, -1, b);
        check_eq("beats_3_2_gated", 64'(b), 64'd1600);

        issue(5, 12);
        check_eq("err_cycle", {60'b0, req_ready, done, err, pix_valid}, 64'b0010);
        @(posedge Clk); #1;
        check_eq("err_back_idle", {60'b0, req_ready, done, err, pix_valid}, 64'b1000);

        issue(7, 5);
        stream_tile(7, 5, 1'b0, 700, b);
        check_eq("abort_beats", 64'(b), 64'd700);
        issue(1, 1);
        stream_tile(1, 1, 1'b0, -1, b);
        check_eq("beats_1_1", 64'(b), 64'd1600);

        // Requester keeps req_valid up with the next tile while the first streams.
        issue(2, 0);
        tile_x    = 4'd2;
        tile_y    = 4'd1;
        req_valid = 1'b1;
        stream_tile(2, 0, 1'b0, -1, b);
        check_eq("beats_2_0", 64'(b), 64'd1600);
        @(posedge Clk); #1;
        req_valid = 1'b0;
        stream_tile(2, 1, 1'b0, -1, b);
        check_eq("beats_2_1", 64'(b), 64'd1600);

        for (int k = 0; k < 2; k++) begin
            tx = int'($urandom_range(0, 15));
            ty = int'($urandom_range(0, 11));
            issue(tx, ty);
            stream_tile(tx, ty, 1'($urandom_range(0, 1)), -1, b);
            check_eq("beats_random", 64'(b), 64'd1600);
        end

        issue(int'($urandom_range(0, 15)), int'($urandom_range(12, 15)));
        check_eq("err_random", {60'b0, req_ready, done, err, pix_valid}, 64'b0010);
        @(posedge Clk); #1;
        check_eq("err_random_idle", {60'b0, req_ready, done, err, pix_valid}, 64'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
